// File: rtl/sid_pkg.sv
// Shared SID types: the host-side bus bundle, the player command word and
// the player FSM states.
package sid;

  localparam int ADDR_W        = 5;
  localparam int PLAYER_WAIT_W = 16;

  typedef logic [7:0] reg8_t;

  // Host-side bus as seen by the responder.
  typedef struct packed {
    logic              phi2;
    logic              res;
    logic              r_w_n;
    logic [ADDR_W-1:0] addr;
    reg8_t             data;
  } bus_i_t;

  // One queued register access; wait_periods idle phi2 periods precede it.
  typedef struct packed {
    logic                     r_w_n;
    logic [1:0]               cs;
    logic [4:0]               addr;
    reg8_t                    data;
    logic [PLAYER_WAIT_W-1:0] wait_periods;
  } player_cmd_t;

  localparam int PLAYER_CMD_W = $bits(player_cmd_t);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    XFER
  } player_state_t;

endpackage

// File: rtl/sid_cmd_fifo.sv
// Synchronous first-word-fall-through FIFO. The head entry is always on dout
// while empty is low; a push becomes visible to pop on the following clock.
module sid_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             res,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // The extra pointer MSB tells a full FIFO apart from an empty one.
  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign dout      = r_mem[r_rd_ptr[AW-1:0]];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Pointer update; reset flushes the queue.
  always_ff @(posedge clk) begin
    if (res) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Storage write.
  // NOTE: the array has no reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/sid_bus_player.sv
// Bus initiator for the SID register file. Queued commands are replayed as
// phi2-framed bus cycles; reads return the responder data as a one-clock
// response pulse. Every output is a flop loaded from next-cycle state, so the
// bus fields always describe the same phase together.
module sid_bus_player
  import sid::*;
#(
  parameter int PHI2_HALF  = 12,
  parameter int FIFO_DEPTH = 16,
  parameter int WAIT_W     = 16
) (
  input  logic        clk,
  input  logic        res,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  player_cmd_t cmd,
  output logic        rsp_valid,
  output reg8_t       rsp_data,
  output bus_i_t      bus_o,
  output logic [1:0]  cs_o,
  input  reg8_t       data_i,
  output logic        busy
);

  localparam int                PH_PERIOD = 2 * PHI2_HALF;
  localparam int                PH_W      = $clog2(PH_PERIOD);
  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(PH_PERIOD - 1);
  localparam logic [PH_W-1:0]   PH_SAMPLE = PH_W'(PHI2_HALF - 1);
  localparam logic [PH_W-1:0]   PH_LOW    = PH_W'(PHI2_HALF);
  localparam logic [PH_W-1:0]   PH_ONE    = PH_W'(1);
  localparam int                FILL_W    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(FIFO_DEPTH);
  localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

  // State registers.
  logic                     r_run;       // low only on the first clock after res
  logic [PH_W-1:0]          r_ph;
  player_state_t            r_state;
  logic [WAIT_W-1:0]        r_wait_cnt;
  logic [FILL_W-1:0]        r_fill;      // FIFO occupancy, feeds cmd_ready/busy
  logic                     r_xfer_rw_n;
  logic [1:0]               r_xfer_cs;
  logic [4:0]               r_xfer_addr;
  reg8_t                    r_xfer_data;

  // Output registers.
  logic                     r_cmd_ready;
  logic                     r_rsp_valid;
  reg8_t                    r_rsp_data;
  bus_i_t                   r_bus;
  logic [1:0]               r_cs;
  logic                     r_busy;

  // FIFO interface.
  logic                     w_push;
  logic                     w_pop;
  logic                     w_fifo_full;
  logic                     w_fifo_empty;
  logic [PLAYER_CMD_W-1:0]  w_fifo_dout;
  player_cmd_t              w_head;
  logic [WAIT_W-1:0]        w_head_wait;

  // Next-state values.
  logic                     w_period_end;
  logic [PH_W-1:0]          w_ph_next;
  player_state_t            w_state_next;
  logic [WAIT_W-1:0]        w_wait_next;
  logic                     w_load;
  logic [FILL_W-1:0]        w_fill_next;
  logic                     w_x_rw_n;
  logic [1:0]               w_x_cs;
  logic [4:0]               w_x_addr;
  reg8_t                    w_x_data;

  sid_cmd_fifo #(
    .WIDTH (PLAYER_CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .res   (res),
    .push  (w_push),
    .din   (cmd),
    .full  (w_fifo_full),
    .pop   (w_pop),
    .dout  (w_fifo_dout),
    .empty (w_fifo_empty)
  );

  assign w_head      = w_fifo_dout;
  assign w_head_wait = WAIT_W'(w_head.wait_periods);

  // Phase advance, end-of-period FSM decision, FIFO handshake and occupancy.
  // NOTE: every signal gets a default before any branch, so no latch is inferred.
  always_comb begin
    w_period_end = r_run && (r_ph == PH_LAST);
    w_ph_next    = '0;
    if (r_run && !w_period_end) w_ph_next = r_ph + PH_ONE;

    w_state_next = r_state;
    w_wait_next  = r_wait_cnt;
    w_pop        = 1'b0;
    w_load       = 1'b0;
    if (w_period_end) begin
      case (r_state)
        WAIT: begin
          if (r_wait_cnt == WAIT_ONE) w_state_next = XFER;
          else                        w_wait_next  = r_wait_cnt - WAIT_ONE;
        end
        default: begin
          // IDLE and XFER both fetch the next command, back to back.
          if (w_fifo_empty) begin
            w_state_next = IDLE;
          end else begin
            w_pop        = 1'b1;
            w_load       = 1'b1;
            w_wait_next  = w_head_wait;
            w_state_next = (w_head_wait != '0) ? WAIT : XFER;
          end
        end
      endcase
    end

    w_x_rw_n = w_load ? w_head.r_w_n : r_xfer_rw_n;
    w_x_cs   = w_load ? w_head.cs    : r_xfer_cs;
    w_x_addr = w_load ? w_head.addr  : r_xfer_addr;
    w_x_data = w_load ? w_head.data  : r_xfer_data;

    w_push      = cmd_valid && r_cmd_ready && !w_fifo_full;
    w_fill_next = r_fill;
    if (w_push && !w_pop)      w_fill_next = r_fill + FILL_ONE;
    else if (!w_push && w_pop) w_fill_next = r_fill - FILL_ONE;
  end

  // FSM, counters and registered outputs; res overrides everything on any clock.
  // NOTE: sequential state uses non-blocking assignments only, so all flops see pre-edge values.
  always_ff @(posedge clk) begin
    if (res) begin
      r_run       <= 1'b0;
      r_ph        <= '0;
      r_state     <= IDLE;
      r_wait_cnt  <= '0;
      r_fill      <= '0;
      r_xfer_rw_n <= 1'b1;
      r_xfer_cs   <= 2'b00;
      r_xfer_addr <= '0;
      r_xfer_data <= '0;
      r_cmd_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_bus       <= '{phi2: 1'b0, res: 1'b1, r_w_n: 1'b1, addr: '0, data: '0};
      r_cs        <= 2'b00;
    end else begin
      r_run       <= 1'b1;
      r_ph        <= w_ph_next;
      r_state     <= w_state_next;
      r_wait_cnt  <= w_wait_next;
      r_fill      <= w_fill_next;
      r_xfer_rw_n <= w_x_rw_n;
      r_xfer_cs   <= w_x_cs;
      r_xfer_addr <= w_x_addr;
      r_xfer_data <= w_x_data;

      r_cmd_ready <= (w_fill_next != FILL_FULL);
      r_busy      <= (w_fill_next != '0) || (w_state_next != IDLE);

      r_bus.phi2  <= (w_ph_next < PH_LOW);
      r_bus.res   <= 1'b0;
      if (w_state_next == XFER) begin
        // The whole period carries the command; writes hold r_w_n low throughout.
        r_bus.r_w_n <= w_x_rw_n;
        r_bus.addr  <= ADDR_W'(w_x_addr);
        if (!w_x_rw_n) r_bus.data <= w_x_data;
        r_cs        <= w_x_cs;
      end else begin
        // Idle bus keeps addr/data from the previous transfer.
        r_bus.r_w_n <= 1'b1;
        r_cs        <= 2'b00;
      end

      // data_i follows the bus outputs, so r_ph is the phase the responder sees.
      r_rsp_valid <= 1'b0;
      if (r_state == XFER && r_xfer_rw_n && r_ph == PH_SAMPLE) begin
        r_rsp_data  <= data_i;
        r_rsp_valid <= 1'b1;
      end
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign bus_o     = r_bus;
  assign cs_o      = r_cs;
  assign busy      = r_busy;

endmodule
